// File: rtl/ahb_vga_wbuf_if.sv
// ---------------------------------------------------------------------------
// ahb_vga_wbuf_if
// AHB-Lite signal bundle shared by both sides of the VGA posted-write buffer.
//   master modport : used by a block that issues transfers
//                    (drives HSEL/HADDR/HTRANS/HWRITE/HWDATA, samples HREADY)
//   slave modport  : used by a block that answers transfers
//                    (samples the request and bus HREADY,
//                     drives HREADYOUT/HRDATA)
// On the master side, HREADY carries the HREADYOUT of the downstream slave.
// ---------------------------------------------------------------------------
interface ahb_vga_wbuf_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        input  HREADY
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/ahb_vga_wbuf.sv
// ---------------------------------------------------------------------------
// ahb_vga_wbuf
// Posted-write buffer that sits in front of the AHB VGA peripheral. CPU
// writes are accepted with zero wait states and queued as {address, byte}
// pairs. They are then replayed in order as single non-pipelined AHB-Lite
// writes to the VGA slave. The CPU stalls only when the queue is full.
//
// Ports
//   HCLK, HRESET : clock, asynchronous active-high reset
//   s_bus        : slave side (S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HWDATA,
//                  S_HREADY in; S_HREADYOUT, S_HRDATA out)
//   m_bus        : master side toward the VGA slave (M_HSEL, M_HADDR,
//                  M_HTRANS, M_HWRITE, M_HWDATA out; M_HREADY in)
//   empty, full  : queue status
//
// Parameters
//   DEPTH : queue entries, power of two in 2..64
//   AW    : stored address bits; HADDR[AW-1:0] is forwarded zero-extended
//
// Build option
//   VGA_WBUF_STATUS_EN : when defined, a read returns
//                        {16'h0, count, 6'h0, full, empty}; otherwise reads
//                        return zero.
// ---------------------------------------------------------------------------
module ahb_vga_wbuf #(
    parameter int DEPTH = 16,
    parameter int AW    = 24
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_vga_wbuf_if.slave  s_bus,
    ahb_vga_wbuf_if.master m_bus,
    output logic           empty,
    output logic           full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state_q, state_d;
    logic          pend_wr_q, pend_wr_d;
    logic          pend_rd_q, pend_rd_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    data_q, data_d;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [7:0]    mem_data [DEPTH];

    logic addr_phase;
    logic push;
    logic pop;

    // Status and handshake terms. full uses the registered count, so a
    // full queue cannot accept a push even in a cycle that also pops.
    always_comb begin
        addr_phase = s_bus.HSEL & s_bus.HREADY & s_bus.HTRANS[1];
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        push       = pend_wr_q & ~full;
        pop        = (state_q == DATA) & m_bus.HREADY;
    end

    assign s_bus.HREADYOUT = ~(pend_wr_q & full);

    // Slave address-phase capture. The pending flags only move while the
    // bus is ready, so a stalled write keeps its address until it is pushed.
    always_comb begin
        pend_wr_d   = pend_wr_q;
        pend_rd_d   = pend_rd_q;
        pend_addr_d = pend_addr_q;
        if (s_bus.HREADY) begin
            pend_wr_d = addr_phase & s_bus.HWRITE;
            pend_rd_d = addr_phase & ~s_bus.HWRITE;
            if (addr_phase) begin
                pend_addr_d = s_bus.HADDR[AW-1:0];
            end
        end
    end

    // Queue pointers and occupancy. Pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Queue storage needs no reset; entries are only read once counted.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= pend_addr_q;
            mem_data[wr_ptr_q] <= s_bus.HWDATA[7:0];
        end
    end

    // Replay FSM: one transfer at a time, address phase then data phase.
    // The byte is latched when the address phase is accepted so M_HWDATA
    // stays stable however long the VGA slave stretches the data phase.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        m_bus.HSEL   = 1'b0;
        m_bus.HTRANS = 2'b00;
        m_bus.HADDR  = 32'h0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_bus.HSEL   = 1'b1;
                m_bus.HTRANS = 2'b10;
                m_bus.HADDR  = 32'(mem_addr[rd_ptr_q]);
                if (m_bus.HREADY) begin
                    data_d  = mem_data[rd_ptr_q];
                    state_d = DATA;
                end
            end
            DATA: begin
                // count still includes the entry being popped here
                if (m_bus.HREADY) begin
                    state_d = (count_q > CW'(1)) ? ADDR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_bus.HWRITE = 1'b1;
    assign m_bus.HWDATA = {24'h0, data_q};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            pend_wr_q   <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= 8'h0;
        end else begin
            state_q     <= state_d;
            pend_wr_q   <= pend_wr_d;
            pend_rd_q   <= pend_rd_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
        end
    end

`ifdef VGA_WBUF_STATUS_EN
    // Status word is presented during the read data phase.
    assign s_bus.HRDATA = pend_rd_q ? {16'h0, 8'(count_q), 6'h0, full, empty}
                                    : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{s_bus.HADDR, s_bus.HWDATA[31:8]};
`else
    assign s_bus.HRDATA = 32'h0;

    logic unused_bits;
    assign unused_bits = ^{s_bus.HADDR, s_bus.HWDATA[31:8], pend_rd_q};
`endif

endmodule

// File: tb/tb_ahb_vga_wbuf.sv
// ---------------------------------------------------------------------------
// tb_ahb_vga_wbuf
// Self-checking bench for ahb_vga_wbuf. A table of single writes checks
// address truncation and byte forwarding; hand-written sequences cover
// reset, a full queue, random VGA stalls, simultaneous push/pop and the
// status read. A monitor on the master side records every completed
// replayed transfer and checks that M_HWDATA holds steady during stalls.
// ---------------------------------------------------------------------------
module tb_ahb_vga_wbuf;

    typedef struct {
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    logic empty;
    logic full;
    logic m_hready = 1'b1;

    ahb_vga_wbuf_if s_bus();
    ahb_vga_wbuf_if m_bus();

    // Single-slave system: the bus HREADY is this slave's HREADYOUT.
    assign s_bus.HREADY = s_bus.HREADYOUT;
    assign m_bus.HREADY = m_hready;

    ahb_vga_wbuf #(.DEPTH(16), .AW(24)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .s_bus  (s_bus.slave),
        .m_bus  (m_bus.master),
        .empty  (empty),
        .full   (full)
    );

    always #5 HCLK = ~HCLK;

    int          pass_cnt  = 0;
    int          check_cnt = 0;
    int          stall_cnt = 0;
    logic        rand_mode = 1'b0;
    logic [31:0] pend_data = 32'h0;
    xfer_t       exp_q[$];
    xfer_t       obs_q[$];
    vec_t        vecs[4];

    logic        mon_in_data = 1'b0;
    logic        mon_first   = 1'b0;
    logic [31:0] mon_addr    = 32'h0;
    logic [31:0] mon_hold    = 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        check_cnt++;
        if (act !== req) begin
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic abort_run(input string name);
        check_cnt++;
        $display("[TB] FAIL %s: wait bound expired", name);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
        if (rand_mode) begin
            m_hready = 1'($urandom_range(0, 1));
        end
    endtask

    // Drive one address phase; HWDATA carries the previous write's data.
    task automatic drive_phase(input logic sel, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
        s_bus.HSEL   = sel;
        s_bus.HTRANS = sel ? 2'b10 : 2'b00;
        s_bus.HWRITE = wr;
        s_bus.HADDR  = addr;
        s_bus.HWDATA = pend_data;
        pend_data    = data;
        if (sel && wr) begin
            exp_q.push_back('{addr & 32'h00FF_FFFF, data & 32'h0000_00FF});
        end
    endtask

    // Hold the current phase until the slave is ready, then pass the edge.
    task automatic wait_ready();
        int n = 0;
        @(negedge HCLK);
        while (!s_bus.HREADYOUT) begin
            n++;
            stall_cnt++;
            if (n > 500) abort_run("wait_ready");
            step();
            @(negedge HCLK);
        end
        step();
    endtask

    task automatic issue(input logic sel, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        drive_phase(sel, wr, addr, data);
        wait_ready();
    endtask

    task automatic wait_drain(input int target);
        int n = 0;
        while (obs_q.size() < target) begin
            n++;
            if (n > 3000) abort_run("wait_drain");
            step();
        end
        step();
        step();
    endtask

    task automatic do_reset();
        drive_phase(1'b0, 1'b0, 32'h0, 32'h0);
        pend_data = 32'h0;
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        step();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic compare_scoreboard(input string tag);
        checkOutput({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput($sformatf("%s addr[%0d]", tag, i), obs_q[i].addr, exp_q[i].addr);
            checkOutput($sformatf("%s data[%0d]", tag, i), obs_q[i].data, exp_q[i].data);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // One table entry: a single write with the VGA slave always ready.
    task automatic applyStimulus(input vec_t v, output xfer_t got);
        m_hready = 1'b1;
        issue(1'b1, 1'b1, v.haddr, v.hwdata);
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        wait_drain(1);
        got = obs_q[0];
        exp_q.delete();
        obs_q.delete();
    endtask

    // Master-side monitor: records completed transfers and checks that the
    // write data does not move while the VGA slave stalls the data phase.
    always @(negedge HCLK) begin
        if (HRESET) begin
            mon_in_data = 1'b0;
        end else if (mon_in_data) begin
            if (mon_first) begin
                mon_hold  = m_bus.HWDATA;
                mon_first = 1'b0;
            end else begin
                checkOutput("m_hwdata stable", m_bus.HWDATA, mon_hold);
            end
            if (m_bus.HREADY) begin
                obs_q.push_back('{mon_addr, m_bus.HWDATA});
                mon_in_data = 1'b0;
            end
        end else if (m_bus.HSEL && m_bus.HTRANS == 2'b10 && m_bus.HREADY) begin
            checkOutput("m_hwrite", 32'(m_bus.HWRITE), 32'd1);
            mon_addr    = m_bus.HADDR;
            mon_in_data = 1'b1;
            mon_first   = 1'b1;
        end
    end

    initial begin
        #900000;
        abort_run("global_timeout");
    end

    initial begin
        xfer_t       got;
        logic [31:0] exp_rd;

        vecs[0] = '{32'h5000_0000, 32'h0000_0041, 32'h0000_0000, 32'h0000_0041};
        vecs[1] = '{32'h50FF_FFFC, 32'h0000_00A5, 32'h00FF_FFFC, 32'h0000_00A5};
        vecs[2] = '{32'h5012_3456, 32'hDEAD_BE7F, 32'h0012_3456, 32'h0000_007F};
        vecs[3] = '{32'hFFFF_FFFF, 32'h1234_5680, 32'h00FF_FFFF, 32'h0000_0080};

        s_bus.HSEL   = 1'b0;
        s_bus.HTRANS = 2'b00;
        s_bus.HWRITE = 1'b0;
        s_bus.HADDR  = 32'h0;
        s_bus.HWDATA = 32'h0;

        // Reset values
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checkOutput("rst s_hreadyout", 32'(s_bus.HREADYOUT), 32'd1);
        checkOutput("rst s_hrdata",    s_bus.HRDATA,         32'h0);
        checkOutput("rst m_htrans",    32'(m_bus.HTRANS),    32'd0);
        checkOutput("rst m_hsel",      32'(m_bus.HSEL),      32'd0);
        checkOutput("rst m_haddr",     m_bus.HADDR,          32'h0);
        checkOutput("rst m_hwdata",    m_bus.HWDATA,         32'h0);
        checkOutput("rst empty",       32'(empty),           32'd1);
        checkOutput("rst full",        32'(full),            32'd0);
        step();
        HRESET = 1'b0;
        step();

        // Single writes from the table
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], got);
            checkOutput($sformatf("vec%0d m_haddr", i),  got.addr, vecs[i].exp_maddr);
            checkOutput($sformatf("vec%0d m_hwdata", i), got.data, vecs[i].exp_mwdata);
            @(negedge HCLK);
            checkOutput($sformatf("vec%0d empty", i), 32'(empty), 32'd1);
            step();
        end

        // Sixteen writes into a stalled VGA slave, then a seventeenth
        m_hready = 1'b0;
        step();
        stall_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            issue(1'b1, 1'b1, 32'h5000_0100 + 32'(4 * k), 32'h0000_0010 + 32'(k));
        end
        issue(1'b1, 1'b1, 32'h5000_0200, 32'h0000_00C3);
        checkOutput("burst16 stalls", 32'(stall_cnt), 32'd0);
        drive_phase(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge HCLK);
        checkOutput("burst16 full",      32'(full),             32'd1);
        checkOutput("w17 stalled",       32'(s_bus.HREADYOUT),  32'd0);
        repeat (3) step();
        @(negedge HCLK);
        checkOutput("w17 still stalled", 32'(s_bus.HREADYOUT),  32'd0);
        m_hready = 1'b1;
        wait_ready();
        wait_drain(17);
        compare_scoreboard("burst17");

        // Forty writes with the VGA slave stalling at random
        rand_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            issue(1'b1, 1'b1, 32'h5000_0004 + 32'(4 * k), 32'hA5A5_0000 | 32'((k * 37 + 5) % 256));
        end
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        wait_drain(40);
        rand_mode = 1'b0;
        m_hready  = 1'b1;
        compare_scoreboard("rand40");

        // Push and pop in the same cycle with five entries queued
        m_hready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 1'b1, 32'h5000_0300 + 32'(4 * k), 32'h0000_0060 + 32'(k));
        end
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        m_hready = 1'b1;
        step();
        m_hready = 1'b0;
        issue(1'b1, 1'b1, 32'h5000_0314, 32'h0000_0065);
        drive_phase(1'b0, 1'b0, 32'h0, 32'h0);
        m_hready = 1'b1;
        @(negedge HCLK);
        checkOutput("pp before count",  32'(dut.count_q),     32'd5);
        checkOutput("pp before wr_ptr", 32'(dut.wr_ptr_q),    32'd5);
        checkOutput("pp before rd_ptr", 32'(dut.rd_ptr_q),    32'd0);
        checkOutput("pp hreadyout",     32'(s_bus.HREADYOUT), 32'd1);
        step();
        @(negedge HCLK);
        checkOutput("pp after count",   32'(dut.count_q),     32'd5);
        checkOutput("pp after wr_ptr",  32'(dut.wr_ptr_q),    32'd6);
        checkOutput("pp after rd_ptr",  32'(dut.rd_ptr_q),    32'd1);
        step();
        wait_drain(6);
        compare_scoreboard("pushpop");

        // Status read with three writes held in the queue
`ifdef VGA_WBUF_STATUS_EN
        exp_rd = 32'h0000_0300;
`else
        exp_rd = 32'h0000_0000;
`endif
        m_hready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 1'b1, 32'h5000_0400 + 32'(4 * k), 32'h0000_0070 + 32'(k));
        end
        issue(1'b1, 1'b0, 32'h5000_0000, 32'h0);
        drive_phase(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge HCLK);
        checkOutput("status hrdata",    s_bus.HRDATA,         exp_rd);
        checkOutput("read zero wait",   32'(s_bus.HREADYOUT), 32'd1);
        step();
        m_hready = 1'b1;
        wait_drain(3);
        compare_scoreboard("status");

        // Reset in the middle of a replayed transfer with three queued
        m_hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 1'b1, 32'h5000_0500 + 32'(4 * k), 32'h0000_0080 + 32'(k));
        end
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        m_hready = 1'b1;
        step();
        HRESET = 1'b1;
        @(negedge HCLK);
        checkOutput("midrst empty",       32'(empty),            32'd1);
        checkOutput("midrst full",        32'(full),             32'd0);
        checkOutput("midrst m_htrans",    32'(m_bus.HTRANS),     32'd0);
        checkOutput("midrst m_hsel",      32'(m_bus.HSEL),       32'd0);
        checkOutput("midrst s_hreadyout", 32'(s_bus.HREADYOUT),  32'd1);
        step();
        HRESET = 1'b0;
        exp_q.delete();
        obs_q.delete();
        repeat (10) step();
        @(negedge HCLK);
        checkOutput("midrst no replay",   32'(obs_q.size()),     32'd0);
        checkOutput("midrst idle htrans", 32'(m_bus.HTRANS),     32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_vga_wbuf.md
Name: ahb_vga_wbuf

Overview:
- Posted-write buffer placed directly upstream of the AHB VGA peripheral.
- Accepts AHB-Lite writes from the bus matrix with zero wait states.
- Queues each write as an {address, byte} pair in a FIFO and replays it, in order, as AHB-Lite write transfers to the VGA slave.
- The CPU therefore does not stall while the console scrolls, which holds the VGA slave's HREADYOUT low; it stalls only when the FIFO is full.

Parameters:
- DEPTH, 16, FIFO entries; power of two, range 2..64.
- AW, 24, stored address bits; HADDR[AW-1:0] is forwarded and upper bits are zero-filled.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset, asynchronous, active-high
- S_HSEL  in  1  slave select
- S_HADDR  in  32  slave address
- S_HTRANS  in  2  slave transfer type
- S_HWRITE  in  1  slave write
- S_HWDATA  in  32  slave write data; only [7:0] is stored
- S_HREADY  in  1  bus HREADY
- S_HREADYOUT  out  1  slave ready
- S_HRDATA  out  32  slave read data
- M_HADDR  out  32  address to VGA slave
- M_HTRANS  out  2  transfer type to VGA slave
- M_HWRITE  out  1  constant 1
- M_HSEL  out  1  select to VGA slave
- M_HWDATA  out  32  {24'h0, byte} to VGA slave
- M_HREADY  in  1  HREADYOUT of the VGA slave
- empty  out  1  FIFO empty
- full  out  1  FIFO full

Behaviour:
- Reset values:
  - S_HREADYOUT=1, S_HRDATA=0.
  - M_HTRANS=2'b00, M_HSEL=0, M_HADDR=0, M_HWDATA=0.
  - FIFO pointers and count = 0; empty=1, full=0; master FSM in IDLE.
  - Reset mid-operation discards all queued entries and any in-flight transfer.
- Slave address phase: when S_HSEL & S_HREADY & S_HTRANS[1], register pend_wr=S_HWRITE, pend_rd=~S_HWRITE, and pend_addr=S_HADDR[AW-1:0]. Otherwise clear pend_wr and pend_rd (only when S_HREADY=1).
- Slave data phase, write:
  - S_HREADYOUT = ~(pend_wr & full).
  - Push {pend_addr, S_HWDATA[7:0]} in the cycle where pend_wr & ~full.
  - The pushed entry is visible to the master FSM on the next cycle.
- Slave data phase, read: always zero wait states; S_HRDATA is defined under Optional Feature.
- Simultaneous push and pop: count is unchanged and both happen.
  - Push into a full FIFO in the same cycle as a pop is NOT allowed; the slave stays stalled for that cycle (full is evaluated on the registered count).
- Pointers: log2(DEPTH) bits, natural wrap. count is log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- Master FSM, non-pipelined, one transfer at a time:
  - IDLE: if ~empty, go to ADDR.
  - ADDR: drive M_HSEL=1, M_HTRANS=2'b10, and M_HADDR={zeros, head.addr}. When M_HREADY=1, latch head.data and go to DATA.
  - DATA: drive M_HTRANS=2'b00, M_HSEL=0, and M_HWDATA={24'h0, data}; hold M_HWDATA stable while M_HREADY=0. When M_HREADY=1, pop the head; go to ADDR if count>1, else IDLE.
- Latency: a write whose data phase ends at edge N drives its address phase from cycle N+1 (IDLE→ADDR transition), earliest NONSEQ at N+2.
- Ordering: strictly FIFO; addresses and bytes are forwarded unmodified.

Optional Feature:
- Macro: VGA_WBUF_STATUS_EN.
- Defined: a read returns S_HRDATA = {16'h0, 8'(count), 6'h0, full, empty}, captured in the read data phase.
- Not defined: S_HRDATA = 32'h0 always, and the count-to-read path is removed.

Test Plan:
- Reset: assert HRESET mid-transfer with 3 entries queued → next cycle empty=1, M_HTRANS=00, S_HREADYOUT=1, and nothing is replayed.
- Single write to 0x5000_0000 with data 0x41, M_HREADY=1 → one NONSEQ on M_HADDR=0x000000, then M_HWDATA=0x00000041, then empty=1.
- Burst of 16 back-to-back writes with M_HREADY held 0 → all 16 accepted with no wait states and full=1. A 17th write sees S_HREADYOUT=0 until M_HREADY rises and one pop completes, then it is accepted. All 17 bytes emerge in order.
- M_HREADY toggled randomly (scroll stalls) with 40 writes to image addresses 0x50000004+4k → M_HWDATA is stable during every stall, no entry is lost or duplicated, and the output sequence matches the input.
- Simultaneous push and pop at count=5 → count stays 5 and the pointers both advance.
- With VGA_WBUF_STATUS_EN defined, read after 3 queued writes with M_HREADY=0 → S_HRDATA=0x0000_0300. Without the macro → 0x0000_0000.
